// File: rtl/multiply_fp32.sv
// multiply_fp32: iterative truncating FP32 multiplier (valid_i/A/B in, Result/busy_o/done_o out, 26-cycle fixed latency)
module multiply_fp32 #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  logic [1:0] state;
  logic sign, zero_flag;
  logic [MAN_W-1:0] ma, mb;
  logic [2*MAN_W-1:0] acc;
  logic [4:0] cnt;
  logic signed [9:0] exp_r, exp_n;
  logic [MAN_W:0] sum;
  logic [22:0] man;
  logic [31:0] res_n;
  always_comb begin
    sum = {1'b0, acc[2*MAN_W-1:MAN_W]} + (mb[0] ? {1'b0, ma} : '0);
    exp_n = exp_r + {9'd0, acc[2*MAN_W-1]};
    man = acc[2*MAN_W-1] ? acc[2*MAN_W-2 -: 23] : acc[2*MAN_W-3 -: 23];
    res_n = zero_flag ? 32'h0 :
            exp_n >= 10'sd255 ? {sign, {EXP_W{1'b1}}, 23'h0} :
            exp_n <= 10'sd0 ? {sign, 31'h0} :
            {sign, exp_n[EXP_W-1:0], man};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      Result <= 32'h0;
      cnt    <= 5'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (valid_i) begin
          sign      <= A[31] ^ B[31];
          ma        <= {1'b1, A[22:0]};
          mb        <= {1'b1, B[22:0]};
          exp_r     <= 10'({2'b0, A[30:23]} + {2'b0, B[30:23]} - 10'(BIAS));
          zero_flag <= (~|A[30:0]) | (~|B[30:0]);
          acc       <= '0;
          cnt       <= 5'd0;
          busy_o    <= 1'b1;
          state     <= MUL;
        end
        MUL: begin
          acc   <= {sum, acc[MAN_W-1:1]};
          mb    <= mb >> 1;
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'(MAN_W-1) ? NORM : MUL;
        end
        NORM: begin
          Result <= res_n;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiply_fp32.sv
// tb_multiply_fp32: scoreboard bench for multiply_fp32 with directed and random vectors
module tb_multiply_fp32;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic valid_i = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [31:0] Result;
  logic busy_o, done_o;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  int acc_q[$];
  multiply_fp32 dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .A(A), .B(B),
    .Result(Result), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    logic s;
    int e;
    if (a[30:0] == 31'h0 || b[30:0] == 31'h0) return 32'h0;
    s = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else m = p[45:23];
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m};
  endfunction
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] req);
    A = a;
    B = b;
    valid_i = 1'b1;
    if (!busy_o) begin
      exp_q.push_back(req);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40 && !done_o; i++) @(negedge clk_i);
    if (!done_o) begin
      n_chk++;
      $display("FAIL done_timeout: got no done_o expected done_o within 40 cycles");
    end
  endtask
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done_o=1 expected no done_o (Result %h)", Result);
      end else begin
        check("result", Result, exp_q.pop_front());
        check("latency", cyc - acc_q.pop_front(), 32'd25);
        check("busy_at_done", {31'h0, busy_o}, 32'h0);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk_i);
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_done", {31'h0, done_o}, 32'h0);
    check("reset_result", Result, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    wait_done();
    @(negedge clk_i);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000);
    wait_done();
    issue(32'hC0000000, 32'h3F000000, 32'hBF800000);
    wait_done();
    issue(32'h00000000, 32'hC0400000, 32'h00000000);
    wait_done();
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000);
    wait_done();
    issue(32'h00800000, 32'h00800000, 32'h00000000);
    wait_done();
    @(negedge clk_i);
    issue(32'h3F800000, 32'h40A00000, 32'h40A00000);
    repeat (3) @(negedge clk_i);
    issue(32'h42000000, 32'h42000000, 32'h0);
    repeat (13) @(negedge clk_i);
    issue(32'hC2000000, 32'h42000000, 32'h0);
    wait_done();
    issue(32'h40400000, 32'h40400000, 32'h41100000);
    wait_done();
    @(negedge clk_i);
    issue(32'h40000000, 32'h40000000, 32'h40800000);
    repeat (8) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midop_reset_busy", {31'h0, busy_o}, 32'h0);
    check("midop_reset_result", Result, 32'h0);
    check("midop_reset_done", {31'h0, done_o}, 32'h0);
    exp_q.delete();
    acc_q.delete();
    rst_i = 1'b0;
    repeat (35) @(negedge clk_i);
    issue(32'hBFC00000, 32'h40000000, 32'hC0400000);
    wait_done();
    @(negedge clk_i);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      issue(a, b, ref_mul(a, b));
      wait_done();
    end
    repeat (30) @(negedge clk_i);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
